// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : mem_initiator
//  Brief    : Initiator-side sequencer for a single-port data memory. Accepts
//             single or burst load/store requests over valid/ready, drives
//             the memory pins, and returns read data on a response stream
//             after a fixed settle latency.
//  Config   : define MEMI_BURST_EN to honour req_len (1..16 beats); when it
//             is undefined every request is a single access.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_initiator #(
    parameter int N   = 10,   // address width (memory depth 2^N words)
    parameter int M   = 16,   // data word width
    parameter int LAT = 1     // mem_addr to mem_rdata sampling latency, 1..4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [N-1:0] req_addr,
    input  logic [M-1:0] req_wdata,
    input  logic [3:0]   req_len,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [M-1:0] rsp_data,
    output logic         rsp_last,
    output logic         busy,
    output logic [N-1:0] mem_addr,
    output logic         mem_we,
    output logic [M-1:0] mem_wdata,
    input  logic [M-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RADDR = 2'd2,
        RRESP = 2'd3
    } state_t;

    // Last settle cycle index; LAT is at most 4 so three bits suffice.
    localparam logic [2:0] LAT_LAST = 3'(LAT - 1);
    localparam logic [N-1:0] ADDR_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [N-1:0]   addr_q,  addr_d;
    logic           we_q,    we_d;
    logic [M-1:0]   wdata_q, wdata_d;
    logic [2:0]     lat_q,   lat_d;
    logic           rvalid_q, rvalid_d;
    logic [M-1:0]   rdata_q,  rdata_d;
    logic           rlast_q,  rlast_d;
    logic           last_beat;

`ifdef MEMI_BURST_EN
    logic [3:0]     beat_q, beat_d;
    logic [3:0]     len_q,  len_d;

    // Current beat is the final one of the registered burst length.
    assign last_beat = (beat_q == len_q);
`else
    // Without bursts every access is a single beat; req_len is ignored.
    logic           unused_len;
    assign unused_len = ^req_len;
    assign last_beat  = 1'b1;
`endif

    // State and datapath registers; reset drops mem_we asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            lat_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
`ifdef MEMI_BURST_EN
            beat_q   <= '0;
            len_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            lat_q    <= lat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
`ifdef MEMI_BURST_EN
            beat_q   <= beat_d;
            len_q    <= len_d;
`endif
        end
    end

    // Next-state and datapath update for the request/beat sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rlast_d  = rlast_q;
`ifdef MEMI_BURST_EN
        beat_d   = beat_q;
        len_d    = len_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    lat_d  = '0;
`ifdef MEMI_BURST_EN
                    beat_d = '0;
                    len_d  = req_len;
`endif
                    if (req_we) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        wdata_d = req_wdata;
                    end else begin
                        state_d = RADDR;
                    end
                end
            end
            WRITE: begin
                // One beat per cycle; the address wraps modulo 2^N.
                if (last_beat) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
`ifdef MEMI_BURST_EN
                    beat_d = beat_q + 4'd1;
`endif
                end
            end
            RADDR: begin
                // Hold the address for LAT cycles, then sample the memory.
                if (lat_q == LAT_LAST) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                    rlast_d  = last_beat;
                    state_d  = RRESP;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RRESP: begin
                // Everything holds until the core takes the beat.
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        lat_d   = '0;
                        state_d = RADDR;
`ifdef MEMI_BURST_EN
                        beat_d  = beat_q + 4'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = rvalid_q;
    assign rsp_data  = rdata_q;
    assign rsp_last  = rlast_q;

endmodule
`default_nettype wire

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Initiator-side sequencer for the CPU's single-port data memory.
- Accepts single or burst requests from the core over a valid/ready handshake, then drives the memory's address, write-enable and write-data pins.
- Samples read data after a fixed settle latency and returns it to the core on a valid/ready response stream.
- Sits between the core's load/store path and the memory array.

Parameters:
N, 10, address width in bits (memory depth 2^N words)
M, 16, data word width in bits
LAT, 1, cycles from driving mem_addr to sampling mem_rdata (range 1..4)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  initiator can accept a request
req_we  input  1  1 = write (fill), 0 = read
req_addr  input  N  start address
req_wdata  input  M  write data; the same word is used for every beat
req_len  input  4  beats minus 1 (0 = single access, 15 = 16 beats)
rsp_valid  output  1  read data valid
rsp_ready  input  1  core accepts read data
rsp_data  output  M  read data
rsp_last  output  1  final beat of a read burst
busy  output  1  request in progress
mem_addr  output  N  to memory address
mem_we  output  1  to memory write enable
mem_wdata  output  M  to memory write data
mem_rdata  input  M  from memory read data

Behaviour:
- Reset (async, reset_n=0): state IDLE; beat count and LAT counter cleared.
- Output values in reset: mem_addr=0, mem_we=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, req_ready=1.
- Reset asserted mid-burst aborts the burst immediately. mem_we falls asynchronously and no further beats are issued.
- req_ready=1 only in IDLE. A request is accepted on a rising edge with req_valid&&req_ready. busy=1 in every state except IDLE.
- Request fields are registered at acceptance; the core may change them afterwards.
- Beat address = req_addr + beat index, modulo 2^N. 0x3FF+1 wraps to 0x000 with no error.
- States are IDLE, WRITE, RADDR, RRESP.
- WRITE:
  - Entered with mem_we=1, mem_addr=A, mem_wdata=req_wdata.
  - One beat per cycle; mem_addr increments each cycle.
  - After beat req_len, return to IDLE; mem_we=0 in the IDLE cycle.
  - A write of L+1 beats accepted at edge T occupies cycles T+1..T+L+1.
- RADDR:
  - mem_addr = beat address, mem_we=0.
  - Wait LAT cycles.
  - On the edge ending the LAT-th cycle, capture mem_rdata into rsp_data, set rsp_valid=1 and go to RRESP.
  - rsp_last=1 when the beat index equals req_len.
  - With LAT=1, the first rsp_valid appears in cycle T+2 after acceptance at edge T.
- RRESP:
  - rsp_data, rsp_last and mem_addr hold stable while rsp_ready=0; backpressure may last any number of cycles.
  - On rsp_valid&&rsp_ready, clear rsp_valid.
  - If that was the last beat, go to IDLE; otherwise increment the beat index and go to RADDR.
  - rsp_valid=0 for at least LAT cycles between beats.
- mem_wdata holds its last written value outside WRITE.
- req_valid during busy is ignored; there is no queueing.

Optional Feature:
- Macro MEMI_BURST_EN.
- Defined: req_len is honoured as above; bursts of 1..16 beats.
- Undefined: req_len is ignored and treated as 0. Every request is a single access, rsp_last=1 on every read response, and the beat counter logic is not compiled.

Test Plan:
- Reset mid write burst (len=7, reset_n low at beat 3) -> mem_we=0 immediately, req_ready=1 and busy=0 after release, no writes after beat 3.
- Single write A=0x010, D=0xBEEF, then single read A=0x010 -> mem_we pulses one cycle; rsp_data=0xBEEF with rsp_last=1 two cycles after read acceptance (LAT=1).
- Fill burst A=0x3FE, len=3, D=0x1234 -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001 with mem_we=1 for exactly 4 cycles; readback of all four equals 0x1234.
- Read burst len=3 with rsp_ready held low 5 cycles on beat 1 -> rsp_data and mem_addr stable during the stall; 4 beats in order, rsp_last only on beat 4.
- req_valid held high through a busy read -> exactly one acceptance; second request accepted in the first IDLE cycle.
- LAT=3 build, single read -> rsp_valid first high in cycle T+4; data matches memory contents.
